// File: rtl/reg_share_pkg.sv
// -----------------------------------------------------------------------------
// reg_share_pkg
//
// Shared definitions for the register-sharing round-robin arbiter.
//
// Contents:
//   arb_state_t : arbiter state (ARB_IDLE = nobody granted, ARB_OWNED = one
//                 requester holds the shared register)
//   next_idx    : wrap-around increment of a requester index, used to move
//                 the priority pointer one past the releasing owner
// -----------------------------------------------------------------------------
package reg_share_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    // Returns idx+1, wrapping to 0 once it reaches n. Callers only pass
    // indices in the range 0..n-1.
    function automatic int next_idx(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage : reg_share_pkg

// File: rtl/reg_share_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Combinational rotating-priority picker. The search starts at index `ptr`
// and walks upward with wrap-around; the first set request bit wins.
//
// Ports:
//   req        in  N   request vector to choose from
//   ptr        in  PW  index that has the highest priority this cycle
//   winner     out N   one-hot winner, all-zero when req is empty
//   winner_idx out PW  binary index of the winner (0 when req is empty)
//   any        out 1   at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [PW-1:0] winner_idx,
    output logic          any
);

    int cand;

    // Walk the N candidate positions in priority order (ptr, ptr+1, ...,
    // wrapping at N). Once a winner has been found `any` is set and later
    // candidates are skipped, so exactly one bit of winner can be high.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        cand       = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!any && req[cand]) begin
                winner[cand] = 1'b1;
                winner_idx   = PW'(cand);
                any          = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/reg_share_arbiter.sv
// -----------------------------------------------------------------------------
// reg_share_arbiter
//
// Round-robin arbiter that shares one WIDTH-bit register among N_REQ
// requesters. One requester owns the register at a time; while it holds its
// request high its data slice is written into the register once per clock.
// A per-requester lock keeps the grant for a short burst of at most MAX_HOLD
// writes. On release the pointer moves one past the old owner and the next
// winner is chosen in the same edge, so the handoff has no idle cycle.
//
// Ports:
//   clk      in  1            rising-edge clock
//   rst_n    in  1            asynchronous active-low reset
//   req      in  N_REQ        per-requester request level
//   lock     in  N_REQ        per-requester burst request (only with req)
//   d_in     in  N_REQ*WIDTH  write data, slice i = d_in[i*WIDTH +: WIDTH]
//   gnt      out N_REQ        registered one-hot grant, or all-zero when idle
//   q        out WIDTH        shared register contents
//   q_valid  out 1            one-cycle pulse after every write to q
//   owner    out OW_W         index of the current or most recent grantee
// -----------------------------------------------------------------------------
module reg_share_arbiter
    import reg_share_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4,
    localparam int OW_W    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ*WIDTH-1:0] d_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic [OW_W-1:0]        owner
);

    // hold_cnt counts writes in the current grant; it never exceeds
    // MAX_HOLD-1 before being cleared, but the extra headroom keeps the
    // comparison constant representable for every legal MAX_HOLD.
    localparam int HC_W = $clog2(MAX_HOLD + 1);

    arb_state_t         state;
    logic [OW_W-1:0]    ptr;
    logic [HC_W-1:0]    hold_cnt;

    logic [OW_W-1:0]    rel_ptr;
    logic [OW_W-1:0]    pick_ptr;
    logic [N_REQ-1:0]   pick_onehot;
    logic [OW_W-1:0]    pick_idx;
    logic               pick_any;

    logic               owner_req;
    logic               owner_lock;
    logic [WIDTH-1:0]   owner_data;
    logic               hold_last;
    logic               do_write;
    logic               do_release;

    // Owner-side decode. The owner's own request, lock and data slice are
    // pulled out of the flattened buses; every other slice is ignored.
    // A write happens whenever the owner still requests. The grant is given
    // up when the owner drops its request, is not locking, or has just done
    // its MAX_HOLD-th consecutive write (hold_cnt reaches MAX_HOLD-1 before
    // the increment, so the write in this edge is the last one).
    always_comb begin
        owner_req  = req[owner];
        owner_lock = lock[owner];
        owner_data = d_in[int'(owner)*WIDTH +: WIDTH];
        hold_last  = (hold_cnt == HC_W'(MAX_HOLD - 1));
        do_write   = (state == ARB_OWNED) && owner_req;
        do_release = (state == ARB_OWNED) &&
                     (!owner_req || !owner_lock || hold_last);
    end

    // Pointer used by the single picker. In IDLE the stored pointer ranks
    // the requests. In OWNED the picker is only consumed on a release, and
    // then it must already see the pointer that the release installs (one
    // past the old owner), so the old owner ends up with lowest priority
    // and is only re-granted when it is the sole requester.
    always_comb begin
        rel_ptr  = OW_W'(next_idx(int'(owner), N_REQ));
        pick_ptr = (state == ARB_OWNED) ? rel_ptr : ptr;
    end

    rr_pick #(
        .N  (N_REQ),
        .PW (OW_W)
    ) u_pick (
        .req        (req),
        .ptr        (pick_ptr),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    // Arbiter state machine together with the shared register it guards.
    // Reset clears everything asynchronously, including a burst in flight.
    // IDLE: grant the picker's winner, if any, without writing.
    // OWNED: write the owner's slice when it requests (q only changes on a
    // write, q_valid pulses for exactly that edge), then either keep the
    // grant and count the write, or release: advance the pointer and hand
    // the grant straight to the next winner, falling back to IDLE when no
    // one is requesting. owner keeps its last value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            owner    <= '0;
            q        <= '0;
            q_valid  <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    q_valid <= 1'b0;
                    if (pick_any) begin
                        gnt      <= pick_onehot;
                        owner    <= pick_idx;
                        hold_cnt <= '0;
                        state    <= ARB_OWNED;
                    end
                end

                ARB_OWNED: begin
                    if (do_write) begin
                        q       <= owner_data;
                        q_valid <= 1'b1;
                    end else begin
                        q_valid <= 1'b0;
                    end

                    if (do_release) begin
                        ptr      <= rel_ptr;
                        hold_cnt <= '0;
                        if (pick_any) begin
                            gnt   <= pick_onehot;
                            owner <= pick_idx;
                        end else begin
                            gnt   <= '0;
                            state <= ARB_IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // The grant vector must never have more than one bit set, and it is
    // non-zero exactly when the arbiter is in OWNED.
    a_gnt_onehot : assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(gnt)
    );

    a_gnt_matches_state : assert property (
        @(posedge clk) disable iff (!rst_n)
        ((gnt != '0) == (state == ARB_OWNED))
    );

endmodule : reg_share_arbiter

// File: tb/tb_reg_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_share_arbiter
//
// Directed testbench for reg_share_arbiter (N_REQ=4, WIDTH=8, MAX_HOLD=4).
// The stimulus process drives vectors on the falling edge, checks grant/owner
// state directly, and pushes the data of every write it expects into a queue.
// A separate monitor pops that queue whenever q_valid is seen.
// -----------------------------------------------------------------------------
module tb_reg_share_arbiter;

    localparam int N_REQ    = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       lock;
    logic [N_REQ*WIDTH-1:0] d_in;
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       q;
    logic                   q_valid;
    logic [1:0]             owner;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];

    reg_share_arbiter #(
        .N_REQ    (N_REQ),
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .lock    (lock),
        .d_in    (d_in),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .owner   (owner)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point shared by stimulus checks and the monitor.
    task automatic compareVal(input string name, input logic [31:0] act,
                              input logic [31:0] req_val);
        checks++;
        if (act !== req_val) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, req_val);
        end
    endtask

    // Checks the four observable outputs against hand-computed values.
    task automatic checkOutput(input string tag, input logic [3:0] e_gnt,
                               input logic [1:0] e_owner, input logic e_qv,
                               input logic [7:0] e_q);
        compareVal({tag, ".gnt"},     32'(gnt),     32'(e_gnt));
        compareVal({tag, ".owner"},   32'(owner),   32'(e_owner));
        compareVal({tag, ".q_valid"}, 32'(q_valid), 32'(e_qv));
        compareVal({tag, ".q"},       32'(q),       32'(e_q));
    endtask

    // Drives one input vector; it is sampled at the next rising edge.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l,
                                 input logic [31:0] d);
        req  = r;
        lock = l;
        d_in = d;
    endtask

    // Records that the next rising edge must write this value to q.
    task automatic expectWrite(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    // Reset with random inputs, check the reset state, and release reset on
    // a falling edge so the caller's next vector meets the first edge.
    task automatic doReset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(4'($urandom), 4'($urandom), $urandom);
        @(negedge clk);
        @(negedge clk);
        checkOutput({tag, "_reset"}, 4'b0000, 2'd0, 1'b0, 8'h00);
        applyStimulus(4'b0000, 4'b0000, 32'h0);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every q_valid pulse consumes one expected write.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && q_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: actual q=%0h required no write", q);
                end else begin
                    e = exp_q.pop_front();
                    compareVal("scoreboard.q", 32'(q), 32'(e));
                end
            end
        end
    end

    // Watchdog so a broken design can never hang the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [3:0] e_gnt;
        rst_n = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 32'h0);

        // Single write from requester 2, re-granted once as sole requester.
        doReset("single");
        applyStimulus(4'b0100, 4'b0000, 32'h00A5_0000);
        @(negedge clk);
        checkOutput("single_grant", 4'b0100, 2'd2, 1'b0, 8'h00);
        expectWrite(8'hA5);
        @(negedge clk);
        checkOutput("single_write", 4'b0100, 2'd2, 1'b1, 8'hA5);
        applyStimulus(4'b0000, 4'b0000, 32'h0);
        @(negedge clk);
        checkOutput("single_idle", 4'b0000, 2'd2, 1'b0, 8'hA5);

        // Everyone requesting: grants rotate 0,1,2,3,0,1 with no bubbles.
        doReset("fair");
        applyStimulus(4'b1111, 4'b0000, 32'h4433_2211);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            e_gnt = 4'b0001 << (k % 4);
            checkOutput($sformatf("fair%0d", k), e_gnt, 2'(k % 4),
                        (k > 0), (k == 0) ? 8'h00 : 8'(8'h11 * (((k - 1) % 4) + 1)));
            if (k < 5) begin
                expectWrite(8'(8'h11 * ((k % 4) + 1)));
            end else begin
                applyStimulus(4'b0000, 4'b0000, 32'h0);
            end
        end
        @(negedge clk);
        checkOutput("fair_idle", 4'b0000, 2'd1, 1'b0, 8'h11);

        // Locked burst from requester 1 is cut after MAX_HOLD writes.
        doReset("burst");
        applyStimulus(4'b1010, 4'b0010, 32'hC300_B000);
        for (int w = 1; w <= MAX_HOLD; w++) begin
            @(negedge clk);
            checkOutput($sformatf("burst%0d", w), 4'b0010, 2'd1, (w > 1),
                        (w == 1) ? 8'h00 : 8'(8'hB0 + w - 1));
            d_in[15:8] = 8'(8'hB0 + w);
            expectWrite(8'(8'hB0 + w));
        end
        @(negedge clk);
        checkOutput("burst_cap", 4'b1000, 2'd3, 1'b1, 8'hB4);
        applyStimulus(4'b0000, 4'b0000, 32'h0);
        @(negedge clk);
        checkOutput("burst_idle", 4'b0000, 2'd3, 1'b0, 8'hB4);

        // Locked owner 0 drops its request after two writes.
        doReset("early");
        applyStimulus(4'b0101, 4'b0001, 32'h0077_00D0);
        for (int w = 1; w <= 2; w++) begin
            @(negedge clk);
            checkOutput($sformatf("early%0d", w), 4'b0001, 2'd0, (w > 1),
                        (w == 1) ? 8'h00 : 8'(8'hD0 + w - 1));
            d_in[7:0] = 8'(8'hD0 + w);
            expectWrite(8'(8'hD0 + w));
        end
        @(negedge clk);
        checkOutput("early_last", 4'b0001, 2'd0, 1'b1, 8'hD2);
        applyStimulus(4'b0100, 4'b0000, 32'h0077_00D9);
        @(negedge clk);
        checkOutput("early_handoff", 4'b0100, 2'd2, 1'b0, 8'hD2);
        expectWrite(8'h77);
        @(negedge clk);
        checkOutput("early_newwrite", 4'b0100, 2'd2, 1'b1, 8'h77);
        applyStimulus(4'b0000, 4'b0000, 32'h0);
        @(negedge clk);
        checkOutput("early_idle", 4'b0000, 2'd2, 1'b0, 8'h77);

        // Reset asserted in the middle of a locked burst clears at once.
        doReset("mid");
        applyStimulus(4'b0010, 4'b0010, 32'h0000_E100);
        @(negedge clk);
        checkOutput("mid_grant", 4'b0010, 2'd1, 1'b0, 8'h00);
        expectWrite(8'hE1);
        @(negedge clk);
        checkOutput("mid_write", 4'b0010, 2'd1, 1'b1, 8'hE1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_async", 4'b0000, 2'd0, 1'b0, 8'h00);
        applyStimulus(4'b0000, 4'b0000, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sole requester 3 is re-granted every cycle; pointer wraps to 0.
        doReset("sole");
        applyStimulus(4'b1000, 4'b0000, 32'hF000_0000);
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            checkOutput($sformatf("sole%0d", w), 4'b1000, 2'd3, (w > 0),
                        (w == 0) ? 8'h00 : 8'(8'hF0 + w - 1));
            d_in[31:24] = 8'(8'hF0 + w);
            expectWrite(8'(8'hF0 + w));
        end
        @(negedge clk);
        checkOutput("sole_last", 4'b1000, 2'd3, 1'b1, 8'hF2);
        applyStimulus(4'b1001, 4'b0000, 32'hF300_005A);
        expectWrite(8'hF3);
        @(negedge clk);
        checkOutput("sole_wrap", 4'b0001, 2'd0, 1'b1, 8'hF3);
        applyStimulus(4'b0000, 4'b0000, 32'h0);
        @(negedge clk);
        checkOutput("sole_idle", 4'b0000, 2'd0, 1'b0, 8'hF3);

        repeat (3) @(negedge clk);
        compareVal("scoreboard.pending", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_reg_share_arbiter
